// File: rtl/test_ctrl_pkg.sv
// rtl/test_ctrl_pkg.sv - shared constants and types for the test-control port
//
// Purpose: register offsets, FSM state encoding, status bit positions and the
// exit code reported on watchdog expiry. No ports.

package test_ctrl_pkg;

  // Register offsets relative to BASE_ADDR (only the low 3 bits are decoded
  // once the address is known to be within the 6-entry window).
  localparam logic [2:0] OFF_CON   = 3'd0;
  localparam logic [2:0] OFF_EXIT  = 3'd1;
  localparam logic [2:0] OFF_CYC   = 3'd2;
  localparam logic [2:0] OFF_SNAP0 = 3'd3;
  localparam logic [2:0] OFF_SNAP1 = 3'd4;
  localparam logic [2:0] OFF_SNAP2 = 3'd5;

  localparam logic [15:0] NUM_REGS = 16'd6;

  // Status register bit positions (offset 0 read).
  localparam int STATUS_EMPTY = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_OVF   = 7;

  localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DONE = 2'd1,
    ST_TOUT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
//
// Purpose: small FIFO whose head entry is always presented on data_o.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i    write request and data
//   pop_i             read request; ignored while empty
//   data_o            head entry, zero while empty
//   full_o, empty_o   occupancy flags
//   drop_o            push_i was refused this cycle (full with no pop)

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign data_o  = empty_o ? '0 : mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/test_ctrl_port.sv
// rtl/test_ctrl_port.sv - CPU-bus test-control responder (console, exit, cycles)
//
// Purpose: decodes six bus addresses from BASE_ADDR, buffers console bytes,
// latches the exit code, runs the cycle counter and watchdog, and reports
// done/pass/timeout to the harness.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   addr, wdata, we          CPU bus (we=1 write, 0 read)
//   hit, rdata               decode hit and combinational read data
//   con_data/valid/ready     console byte stream to the harness
//   done, pass, timeout      test status
//   exit_code                latched exit code (FF on timeout)

module test_ctrl_port
  import test_ctrl_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] TIMEOUT    = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic        hit,
  output logic [7:0]  rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  exit_code
);

  state_e      state_q, state_d;
  logic [7:0]  exit_q, exit_d;
  logic [31:0] cycle_q, wdog_q;
  logic [23:0] snap_q;
  logic        ovf_q;

  logic [15:0] off;
  logic        con_wr, exit_wr, cyc_rd;
  logic        fifo_full, fifo_empty, fifo_drop;
  logic [7:0]  status;
  logic [7:0]  reg_val;

  // Subtract-then-compare keeps the window check correct even when the
  // window sits at the very top of the address space.
  assign off     = addr - BASE_ADDR;
  assign hit     = (off < NUM_REGS);
  assign con_wr  = hit && we  && (off[2:0] == OFF_CON);
  assign exit_wr = hit && we  && (off[2:0] == OFF_EXIT);
  assign cyc_rd  = hit && !we && (off[2:0] == OFF_CYC);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (con_wr),
    .data_i  (wdata),
    .pop_i   (con_ready),
    .data_o  (con_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign con_valid = !fifo_empty;

  always_comb begin
    status               = 8'h00;
    status[STATUS_OVF]   = ovf_q;
    status[STATUS_FULL]  = fifo_full;
    status[STATUS_EMPTY] = fifo_empty;
  end

  always_comb begin
    reg_val = 8'h00;
    case (off[2:0])
      OFF_CON:   reg_val = status;
      OFF_EXIT:  reg_val = exit_q;
      OFF_CYC:   reg_val = cycle_q[7:0];
      OFF_SNAP0: reg_val = snap_q[7:0];
      OFF_SNAP1: reg_val = snap_q[15:8];
      OFF_SNAP2: reg_val = snap_q[23:16];
      default:   reg_val = 8'h00;
    endcase
  end

  assign rdata = hit ? reg_val : 8'h00;

  // An exit write in the same cycle as watchdog expiry wins: the CPU got there first.
  always_comb begin
    state_d = state_q;
    exit_d  = exit_q;
    case (state_q)
      ST_RUN: begin
        if (exit_wr) begin
          state_d = ST_DONE;
          exit_d  = wdata;
        end else if ((TIMEOUT != 32'd0) && (wdog_q == TIMEOUT - 32'd1)) begin
          state_d = ST_TOUT;
          exit_d  = EXIT_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      exit_q  <= 8'h00;
      cycle_q <= 32'd0;
      wdog_q  <= 32'd0;
      snap_q  <= 24'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exit_q  <= exit_d;
      cycle_q <= cycle_q + 32'd1;
      if (state_q == ST_RUN) wdog_q <= wdog_q + 32'd1;
      // Reading the low byte freezes the upper bytes so a multi-byte read is coherent.
      if (cyc_rd) snap_q <= cycle_q[31:8];
      if (fifo_drop) ovf_q <= 1'b1;
    end
  end

  assign done      = (state_q != ST_RUN);
  assign timeout   = (state_q == ST_TOUT);
  assign pass      = (state_q == ST_DONE) && (exit_q == 8'h00);
  assign exit_code = exit_q;

endmodule

// File: doc/test_ctrl_port.md
# test_ctrl_port

Memory-mapped test-control responder sitting on the 6502 CPU data bus in simulation and FPGA test builds. It is the device end of the bench/CPU conversation: the CPU writes console characters and an exit code, reads a free-running cycle counter, and the block reports done/pass/timeout to the harness. Console bytes are buffered in a small FIFO and drained by the harness over a ready/valid port.

## Interface
Parameters:
- BASE_ADDR, 16'hFFF0 — first of 6 decoded bus addresses (BASE..BASE+5).
- FIFO_DEPTH, 8 — console FIFO entries; power of two, ≥2.
- TIMEOUT, 32'd1_000_000 — watchdog limit in clk cycles; 0 disables.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- addr  in  16  CPU address, valid every cycle.
- wdata  in  8  CPU write data.
- we  in  1  CPU write strobe for this cycle (1 = write, 0 = read).
- hit  out  1  addr within BASE..BASE+5 (combinational).
- rdata  out  8  read data (combinational from addr and registers); 8'h00 when !hit.
- con_data  out  8  head console byte.
- con_valid  out  1  FIFO non-empty.
- con_ready  in  1  harness accepts con_data when con_valid & con_ready.
- done  out  1  test finished (exit written or timeout).
- pass  out  1  done & exit_code == 0 & !timeout.
- timeout  out  1  watchdog fired.
- exit_code  out  8  latched exit code.

## Operation
- Register map (offset from BASE_ADDR):
  - +0 W: push wdata into console FIFO. R: status {ovf, 5'b0, full, empty}.
  - +1 W: latch exit_code, enter DONE. R: exit_code.
  - +2 R: cycle[7:0] live; same edge captures cycle[31:8] into snapshot. W: ignored.
  - +3/+4/+5 R: snapshot[7:0]/[15:8]/[23:16]. W: ignored.
- State machine (package enum): RUN → DONE on write to +1; RUN → TOUT when watchdog == TIMEOUT-1 and TIMEOUT≠0. DONE and TOUT are terminal until rst.
- In TOUT: exit_code = 8'hFF, timeout = 1. Exit writes in DONE/TOUT ignored; first write wins.
- Cycle counter: 32-bit, increments every cycle after reset in every state, wraps 2^32-1 → 0. Watchdog: separate 32-bit counter, counts only in RUN.
- FIFO: push on write to +0 when !full; if full (and no pop same cycle), byte dropped and sticky ovf set (cleared only by rst). Push to full with same-cycle pop: accepted, no ovf. Push to empty with pop: pop ignored (nothing valid). Console pushes still accepted in DONE/TOUT (drain of final output).
- Reset values: all counters 0, FIFO empty, ovf 0, state RUN, exit_code 0, done/pass/timeout/con_valid 0, con_data 0.

## Timing
- hit, rdata: combinational, same cycle as addr.
- Write to +0 at edge N → con_valid = 1 after edge N (visible cycle N+1); con_data = first-pushed byte.
- Pop at edge with con_valid & con_ready; next entry visible next cycle; back-to-back pops at 1 byte/cycle.
- Exit write at edge N → done/exit_code/pass valid cycle N+1.
- Timeout: done/timeout asserted exactly TIMEOUT cycles after rst deassertion.
- Snapshot captured at the edge of a cycle reading +2 (we=0, addr=BASE+2).
- rst asserted mid-operation: all state returns to reset values on the next edge; FIFO content lost.

## Structure
- Package test_ctrl_pkg: register offset localparams, state enum {RUN, DONE, TOUT}, status bit positions, timeout exit code 8'hFF.
- Sub-module sync_fifo (width 8, depth parameter, push/pop/full/empty, first-word-fall-through); top holds decode, counters, FSM.

## Test plan
- Reset: after rst, hit/rdata 0 for addr 16'h0000, status read at FFF0 = 8'h01, done=0, con_valid=0.
- Console: write 'H','i' to FFF0, con_ready=1 → con_data 8'h48 then 8'h69 on consecutive cycles, then con_valid=0.
- Overflow: con_ready=0, 9 writes (DEPTH 8) → status 8'h82, 9th byte absent on drain; full+pop+push same cycle → no ovf.
- Exit: write 8'h00 to FFF1 → pass=1 next cycle; later write 8'h05 ignored, exit_code stays 0; write 8'h05 first → done=1, pass=0.
- Timeout: TIMEOUT=50, no exit write → done=timeout=1 exactly 50 cycles after rst release, exit_code 8'hFF.
- Counter: read FFF2 at cycle 300 → 8'h2C; FFF3 → 8'h01 even read later; rst mid-run clears counter and FIFO.
